// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (IF) and MEM stages.
// One transaction in flight at a time; MEM wins unless IF has been passed over STARVE_MAX times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ack,
    output logic              o_if_stall,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_ack,
    output logic              o_mem_stall,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_grant_mem
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_we;
    logic                r_grant_mem;
    logic                r_if_ack;
    logic                r_mem_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                w_req_any;
    logic                w_pick_if;
    logic                w_last_wait;

    assign w_req_any   = i_if_req | i_mem_req;
    assign w_pick_if   = i_if_req & (~i_mem_req | (r_starve_cnt == STARVE_W'(STARVE_MAX)));
    assign w_last_wait = (r_wait_cnt == '0);

    always_comb begin
        // NOTE: every always_comb output is defaulted before the case, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = S_ISSUE;
                    if (w_pick_if) begin
                        w_starve_nxt = '0;
                    end else if (i_if_req && (r_starve_cnt != STARVE_W'(STARVE_MAX))) begin
                        w_starve_nxt = r_starve_cnt + STARVE_W'(1);
                    end
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_last_wait) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: the latched write flag is rewritten at every grant before WAIT reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_req_any) r_we <= ~w_pick_if & i_mem_we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_grant_mem  <= 1'b0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            r_if_ack     <= 1'b0;
            r_mem_ack    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The RAM address/data registers double as the latched request.
                    if (w_req_any) begin
                        r_grant_mem <= ~w_pick_if;
                        r_ram_en    <= 1'b1;
                        r_ram_we    <= ~w_pick_if & i_mem_we;
                        r_ram_addr  <= w_pick_if ? i_if_addr : i_mem_addr;
                        r_ram_wdata <= w_pick_if ? '0 : i_mem_wdata;
                    end
                end
                S_ISSUE: r_wait_cnt <= CNT_W'(MEM_LAT - 1);
                S_WAIT: begin
                    if (w_last_wait) begin
                        if (r_grant_mem) begin
                            r_mem_rdata <= r_we ? '0 : i_ram_rdata;
                            r_mem_ack   <= 1'b1;
                        end else begin
                            r_if_rdata  <= i_ram_rdata;
                            r_if_ack    <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_if_rdata  = r_if_rdata;
    assign o_if_ack    = r_if_ack;
    assign o_if_stall  = i_if_req & ~r_if_ack;
    assign o_mem_rdata = r_mem_rdata;
    assign o_mem_ack   = r_mem_ack;
    assign o_mem_stall = i_mem_req & ~r_mem_ack;
    assign o_ram_en    = r_ram_en;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;
    assign o_grant_mem = r_grant_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a RAM model with MEM_LAT read
// latency, and monitors that compare every ack and every RAM strobe against queued expectations.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 2;

    typedef struct { logic is_mem; logic [31:0] data; int cyc; } ack_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } ram_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_cmd_t;

    logic              clk;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              mem_stall;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              grant_mem;

    ack_exp_t    ack_q[$];
    ram_exp_t    ram_q[$];
    logic [31:0] if_cmds[$];
    mem_cmd_t    mem_cmds[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] hold_if = 0;
    logic [31:0] hold_mem = 0;
    logic [31:0] ram_mem [64];
    logic [31:0] ram_pipe [MEM_LAT];

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
        .o_if_ack(if_ack), .o_if_stall(if_stall),
        .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_ack(mem_ack),
        .o_mem_stall(mem_stall),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata), .o_grant_mem(grant_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: reads return MEM_LAT cycles after the strobe, garbage in every other cycle.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram_mem[i] <= 32'hBAD0_0000 | 32'(i);
            ram_mem[4]  <= 32'h0050_0093;
            ram_mem[5]  <= 32'h0010_0073;
            ram_mem[6]  <= 32'h00A0_0113;
            ram_mem[9]  <= 32'h0020_81B3;
            ram_mem[10] <= 32'h0031_2023;
            ram_mem[16] <= 32'h1122_3344;
            ram_mem[17] <= 32'hCAFE_0001;
            ram_mem[18] <= 32'h0000_1111;
            ram_mem[19] <= 32'h0000_2222;
            ram_mem[20] <= 32'h0000_3333;
            ram_mem[21] <= 32'h0000_4444;
        end else if (ram_en && ram_we) begin
            ram_mem[ram_addr[7:2]] <= ram_wdata;
        end
        ram_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr[7:2]] : (32'hBAD0_0000 + 32'(cyc));
        for (int i = 1; i < MEM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign ram_rdata = ram_pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_ack(input logic is_mem, input logic [31:0] data, input int c);
        ack_exp_t e;
        e.is_mem = is_mem; e.data = data; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic exp_ram(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int c);
        ram_exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata; e.cyc = c;
        ram_q.push_back(e);
    endtask

    task automatic send_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata;
        mem_cmds.push_back(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ack_q.size() != 0 || ram_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (ack_q.size() != 0 || ram_q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL idle_timeout at cycle %0d: got %0d acks and %0d strobes outstanding, want 0",
                     cyc, ack_q.size(), ram_q.size());
        end
        @(negedge clk);
    endtask

    // Requesters hold req until ack, then present the next queued command or drop req.
    initial begin : if_driver
        int n;
        if_req = 1'b0; if_addr = '0;
        forever begin
            @(posedge clk); #1;
            while (if_cmds.size() != 0) begin
                if_addr = if_cmds.pop_front();
                if_req  = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!if_ack && n < 100);
                if (!if_ack) begin
                    n_vec++; n_fail++;
                    $display("FAIL if_ack_timeout at cycle %0d: got no ack, want ack", cyc);
                end
                if (if_cmds.size() == 0) if_req = 1'b0;
            end
        end
    end

    initial begin : mem_driver
        int n;
        mem_cmd_t c;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        forever begin
            @(posedge clk); #1;
            while (mem_cmds.size() != 0) begin
                c = mem_cmds.pop_front();
                mem_we = c.we; mem_addr = c.addr; mem_wdata = c.wdata;
                mem_req = 1'b1;
                n = 0;
                do begin @(negedge clk); n++; end while (!mem_ack && n < 100);
                if (!mem_ack) begin
                    n_vec++; n_fail++;
                    $display("FAIL mem_ack_timeout at cycle %0d: got no ack, want ack", cyc);
                end
                if (mem_cmds.size() == 0) mem_req = 1'b0;
            end
        end
    end

    initial begin : ack_monitor
        ack_exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_if  = '0;
                hold_mem = '0;
            end else if (if_ack || mem_ack) begin
                if (ack_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_ack at cycle %0d: got if_ack=%b mem_ack=%b, want none",
                             cyc, if_ack, mem_ack);
                end else begin
                    e = ack_q.pop_front();
                    check("ack_sel", 32'({if_ack, mem_ack}), e.is_mem ? 32'd1 : 32'd2);
                    check("ack_cycle", cyc, e.cyc);
                    check("grant_mem", 32'(grant_mem), 32'(e.is_mem));
                    if (e.is_mem) begin
                        check("mem_rdata", mem_rdata, e.data);
                        check("if_rdata_hold", if_rdata, hold_if);
                        check("mem_stall_at_ack", 32'(mem_stall), 32'd0);
                        hold_mem = e.data;
                    end else begin
                        check("if_rdata", if_rdata, e.data);
                        check("mem_rdata_hold", mem_rdata, hold_mem);
                        check("if_stall_at_ack", 32'(if_stall), 32'd0);
                        hold_if = e.data;
                    end
                end
            end
        end
    end

    initial begin : ram_monitor
        ram_exp_t e;
        forever begin
            @(negedge clk);
            if (ram_we && !ram_en) begin
                n_vec++; n_fail++;
                $display("FAIL ram_we_alone at cycle %0d: got ram_we=1 ram_en=0, want ram_we=0", cyc);
            end
            if (ram_en) begin
                if (ram_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_ram_en at cycle %0d: got ram_en=1 addr=%h, want 0", cyc, ram_addr);
                end else begin
                    e = ram_q.pop_front();
                    check("ram_cycle", cyc, e.cyc);
                    check("ram_we", 32'(ram_we), 32'(e.we));
                    check("ram_addr", ram_addr, e.addr);
                    check("ram_wdata", ram_wdata, e.wdata);
                end
            end
        end
    end

    initial begin : main
        int t;
        // Reset held with both requesters active; MEM must win the first grant afterwards.
        reset = 1'b1;
        send_mem(1'b0, 32'h44, 32'h0);
        if_cmds.push_back(32'h18);
        exp_ram(1'b0, 32'h44, 32'h0, 3);
        exp_ack(1'b1, 32'hCAFE_0001, 6);
        exp_ram(1'b0, 32'h18, 32'h0, 8);
        exp_ack(1'b0, 32'h00A0_0113, 11);
        repeat (2) begin
            @(negedge clk);
            check("rst_if_ack", 32'(if_ack), 32'd0);
            check("rst_mem_ack", 32'(mem_ack), 32'd0);
            check("rst_ram_en", 32'(ram_en), 32'd0);
            check("rst_ram_we", 32'(ram_we), 32'd0);
            check("rst_ram_addr", ram_addr, 32'd0);
            check("rst_ram_wdata", ram_wdata, 32'd0);
            check("rst_if_rdata", if_rdata, 32'd0);
            check("rst_mem_rdata", mem_rdata, 32'd0);
            check("rst_grant_mem", 32'(grant_mem), 32'd0);
            check("rst_if_stall", 32'(if_stall), 32'd1);
            check("rst_mem_stall", 32'(mem_stall), 32'd1);
        end
        reset = 1'b0;
        wait_idle();

        // Lone fetch.
        t = cyc + 1;
        if_cmds.push_back(32'h10);
        exp_ram(1'b0, 32'h10, 32'h0, t + 1);
        exp_ack(1'b0, 32'h0050_0093, t + 4);
        wait_idle();

        // Simultaneous requests: MEM first, IF right behind.
        t = cyc + 1;
        send_mem(1'b0, 32'h40, 32'h0);
        if_cmds.push_back(32'h14);
        exp_ram(1'b0, 32'h40, 32'h0, t + 1);
        exp_ack(1'b1, 32'h1122_3344, t + 4);
        exp_ram(1'b0, 32'h14, 32'h0, t + 6);
        exp_ack(1'b0, 32'h0010_0073, t + 9);
        wait_idle();

        // Starvation bound: MEM, MEM, IF, MEM, MEM, IF.
        t = cyc + 1;
        send_mem(1'b0, 32'h48, 32'h0);
        send_mem(1'b0, 32'h4C, 32'h0);
        send_mem(1'b0, 32'h50, 32'h0);
        send_mem(1'b0, 32'h54, 32'h0);
        if_cmds.push_back(32'h24);
        if_cmds.push_back(32'h28);
        exp_ram(1'b0, 32'h48, 32'h0, t + 1);  exp_ack(1'b1, 32'h0000_1111, t + 4);
        exp_ram(1'b0, 32'h4C, 32'h0, t + 6);  exp_ack(1'b1, 32'h0000_2222, t + 9);
        exp_ram(1'b0, 32'h24, 32'h0, t + 11); exp_ack(1'b0, 32'h0020_81B3, t + 14);
        exp_ram(1'b0, 32'h50, 32'h0, t + 16); exp_ack(1'b1, 32'h0000_3333, t + 19);
        exp_ram(1'b0, 32'h54, 32'h0, t + 21); exp_ack(1'b1, 32'h0000_4444, t + 24);
        exp_ram(1'b0, 32'h28, 32'h0, t + 26); exp_ack(1'b0, 32'h0031_2023, t + 29);
        repeat (14) begin
            @(negedge clk);
            check("if_stall_starved", 32'(if_stall), 32'd1);
        end
        wait_idle();

        // Store: write strobe with data, ack carries zero read data.
        t = cyc + 1;
        send_mem(1'b1, 32'h20, 32'hDEAD_BEEF);
        exp_ram(1'b1, 32'h20, 32'hDEAD_BEEF, t + 1);
        exp_ack(1'b1, 32'h0, t + 4);
        wait_idle();

        // Reset lands mid-fetch: no ack for the aborted access, held request restarts cleanly.
        t = cyc + 1;
        if_cmds.push_back(32'h10);
        exp_ram(1'b0, 32'h10, 32'h0, t + 1);
        exp_ram(1'b0, 32'h10, 32'h0, t + 4);
        exp_ack(1'b0, 32'h0050_0093, t + 7);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("if_stall_after_abort", 32'(if_stall), 32'd1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog at cycle %0d: got no completion, want $finish", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
